// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DIV_WAIT  = 2'd1,
        TRAP_WAIT = 2'd2
    } state_t;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    // A request at stage k freezes stages k..0, so every mask is a low-order run of ones.
    localparam logic [5:0] MASK_IF   = 6'b000001;
    localparam logic [5:0] MASK_ID   = 6'b000011;
    localparam logic [5:0] MASK_EX   = 6'b000111;
    localparam logic [5:0] MASK_MEM  = 6'b001111;
    localparam logic [5:0] MASK_TRAP = 6'b011111;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running 64-bit performance counters for the pipeline sequencer (wrap modulo 2^64).
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  stall,
    input  logic        div_wait,
    input  logic        flush,
    output logic [63:0] perf_cycles,
    output logic [63:0] perf_stall_id,
    output logic [63:0] perf_stall_div,
    output logic [63:0] perf_flush
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles    <= '0;
            perf_stall_id  <= '0;
            perf_stall_div <= '0;
            perf_flush     <= '0;
        end else begin
            perf_cycles <= perf_cycles + 64'd1;
            if (stall[1] && !stall[2]) perf_stall_id  <= perf_stall_id + 64'd1;
            if (div_wait)              perf_stall_div <= perf_stall_div + 64'd1;
            if (flush)                 perf_flush     <= perf_flush + 64'd1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: stall merge, divide hold with
// watchdog, and trap redirect ordered behind outstanding stores. PIPE_CTRL_PERF_EN adds perf counters.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RUN       | normal flow; per-stage stall requests merged combinationally
// DIV_WAIT  | divide in flight, EX and younger held, watchdog counting
// TRAP_WAIT | trap accepted but a store is outstanding; full freeze
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = 80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        div_start,
    input  logic        div_done,
    input  logic        stallreq_mem,
    input  logic        mem_busy,
    input  logic        excp_req,
    input  logic [63:0] excp_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        excp_ack,
    output logic        div_kill,
    output logic        ctrl_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [63:0] perf_cycles,
    output logic [63:0] perf_stall_id,
    output logic [63:0] perf_stall_div,
    output logic [63:0] perf_flush
`endif
);

    localparam int WD_W = $clog2(DIV_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(DIV_TIMEOUT - 1);

    state_t          state, state_next;
    logic [WD_W-1:0] wd_cnt, wd_next, wd_inc;
    logic [5:0]      req_mask, stall_v;
    logic            flush_v, kill_v, err_set;

    assign wd_inc = wd_cnt + WD_W'(1);

    always_comb begin
        req_mask = 6'b0;
        if (stallreq_mem) req_mask = req_mask | MASK_MEM;
        if (stallreq_id)  req_mask = req_mask | MASK_ID;
        if (stallreq_if)  req_mask = req_mask | MASK_IF;
    end

    always_comb begin
        state_next = state;
        wd_next    = wd_cnt;
        stall_v    = 6'b0;
        flush_v    = 1'b0;
        kill_v     = 1'b0;
        err_set    = 1'b0;
        case (state)
            RUN: begin
                if (excp_req) begin
                    if (!mem_busy) begin
                        flush_v = 1'b1;
                    end else begin
                        stall_v    = MASK_TRAP;
                        state_next = TRAP_WAIT;
                    end
                end else begin
                    stall_v = req_mask;
                    if (div_start) begin
                        stall_v    = stall_v | MASK_EX;
                        wd_next    = '0;
                        state_next = DIV_WAIT;
                    end
                end
            end
            DIV_WAIT: begin
                if (excp_req) begin
                    kill_v = 1'b1;
                    if (!mem_busy) begin
                        flush_v    = 1'b1;
                        state_next = RUN;
                    end else begin
                        stall_v    = MASK_TRAP;
                        state_next = TRAP_WAIT;
                    end
                end else begin
                    stall_v = req_mask;
                    if (div_done) begin
                        state_next = RUN;
                    end else if (wd_inc == WD_LAST) begin
                        // Timeout cycle: the divide is abandoned, so EX is released too.
                        kill_v     = 1'b1;
                        err_set    = 1'b1;
                        state_next = RUN;
                    end else begin
                        stall_v = stall_v | MASK_EX;
                        wd_next = wd_inc;
                    end
                end
            end
            TRAP_WAIT: begin
                if (!mem_busy) begin
                    flush_v    = 1'b1;
                    state_next = RUN;
                end else begin
                    stall_v = MASK_TRAP;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wd_cnt   <= '0;
            ctrl_err <= 1'b0;
        end else begin
            state  <= state_next;
            wd_cnt <= wd_next;
            if (err_set) ctrl_err <= 1'b1;
        end
    end

    // Outputs are forced quiet while reset is held, whatever the requesters drive.
    always_comb begin
        stall          = rst_n ? stall_v : 6'b0;
        flush          = rst_n & flush_v;
        redirect_valid = flush;
        excp_ack       = flush;
        redirect_pc    = flush ? excp_pc : 64'd0;
        div_kill       = rst_n & kill_v;
    end

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_cnt u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .div_wait       (state == DIV_WAIT),
        .flush          (flush),
        .perf_cycles    (perf_cycles),
        .perf_stall_id  (perf_stall_id),
        .perf_stall_div (perf_stall_div),
        .perf_flush     (perf_flush)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_pipe_ctrl;

    localparam int DIV_TIMEOUT = 80;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallreq_if, stallreq_id, div_start, div_done, stallreq_mem, mem_busy, excp_req;
    logic [63:0] excp_pc;
    logic [5:0]  stall;
    logic        flush, redirect_valid, excp_ack, div_kill, ctrl_err;
    logic [63:0] redirect_pc;
`ifdef PIPE_CTRL_PERF_EN
    logic [63:0] perf_cycles, perf_stall_id, perf_stall_div, perf_flush;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state: divide outstanding and its age in cycles, trap parked, sticky error.
    bit m_div, m_trap, m_err;
    int m_age;

    pipe_ctrl #(.DIV_TIMEOUT(DIV_TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stallreq_if    (stallreq_if),
        .stallreq_id    (stallreq_id),
        .div_start      (div_start),
        .div_done       (div_done),
        .stallreq_mem   (stallreq_mem),
        .mem_busy       (mem_busy),
        .excp_req       (excp_req),
        .excp_pc        (excp_pc),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .excp_ack       (excp_ack),
        .div_kill       (div_kill),
        .ctrl_err       (ctrl_err)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_cycles    (perf_cycles),
        .perf_stall_id  (perf_stall_id),
        .perf_stall_div (perf_stall_div),
        .perf_flush     (perf_flush)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs already driven; check outputs mid-cycle, then advance the model at the edge.
    task automatic step(input string tag);
        int   deepest;
        bit   e_fl, e_kill, tmo, hold;
        logic [5:0] e_stall;
        deepest = -1; e_fl = 0; e_kill = 0; tmo = 0; hold = 0;
        #1;
        if (!rst_n) begin
            m_div = 0; m_trap = 0; m_err = 0; m_age = 0;
        end else if (m_trap) begin
            if (!mem_busy) e_fl = 1; else deepest = 4;
        end else if (excp_req) begin
            e_kill = m_div;
            if (!mem_busy) e_fl = 1; else deepest = 4;
        end else begin
            if (m_div) begin
                if (!div_done) begin
                    if (m_age == DIV_TIMEOUT - 1) begin
                        tmo = 1; e_kill = 1;
                    end else hold = 1;
                end
            end else hold = div_start;
            if (stallreq_if  && deepest < 0) deepest = 0;
            if (stallreq_id  && deepest < 1) deepest = 1;
            if (hold         && deepest < 2) deepest = 2;
            if (stallreq_mem && deepest < 3) deepest = 3;
        end
        e_stall = (deepest < 0) ? 6'd0 : 6'((1 << (deepest + 1)) - 1);

        chk({tag, ":stall"},    64'(stall),          64'(e_stall));
        chk({tag, ":flush"},    64'(flush),          64'(e_fl));
        chk({tag, ":redir_v"},  64'(redirect_valid), 64'(e_fl));
        chk({tag, ":ack"},      64'(excp_ack),       64'(e_fl));
        chk({tag, ":redir_pc"}, redirect_pc,         e_fl ? excp_pc : 64'd0);
        chk({tag, ":div_kill"}, 64'(div_kill),       64'(e_kill));
        chk({tag, ":ctrl_err"}, 64'(ctrl_err),       64'(m_err));
        chk({tag, ":excl"},     64'(flush && (stall != 6'd0)), 64'd0);

        @(posedge clk);
        if (rst_n) begin
            if (e_fl) begin
                m_trap = 0; m_div = 0;
            end else if (m_trap || excp_req) begin
                m_trap = 1; m_div = 0;
            end else if (m_div) begin
                if (div_done || tmo) m_div = 0; else m_age++;
                if (tmo) m_err = 1;
            end else if (div_start) begin
                m_div = 1; m_age = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stallreq_if = 0; stallreq_id = 0; div_start = 0; div_done = 0;
        stallreq_mem = 0; mem_busy = 0; excp_req = 0; excp_pc = 64'd0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        m_div = 0; m_trap = 0; m_err = 0; m_age = 0;
        @(negedge clk);
        stallreq_id = 1;
        step("reset_gated");
        idle_inputs();
        rst_n = 1;
        step("idle");

        stallreq_id = 1;
        repeat (2) step("hazard");
        stallreq_id = 0;
        step("hazard_end");

        div_start = 1;
        step("div_start");
        div_start = 0;
        repeat (14) step("div_hold");
        div_done = 1;
        step("div_done");
        div_done = 0;
        step("div_after");

        div_start = 1;
        step("wd_start");
        div_start = 0;
        repeat (79) step("wd_wait");
        repeat (3) step("wd_after");

        excp_req = 1; excp_pc = 64'h0000_0000_8000_0100; mem_busy = 1;
        repeat (3) step("trap_busy");
        mem_busy = 0;
        step("trap_flush");
        excp_req = 0; excp_pc = 64'd0;
        step("trap_after");

        div_start = 1;
        step("tdiv_start");
        div_start = 0;
        repeat (3) step("tdiv_hold");
        excp_req = 1; excp_pc = 64'h0000_0000_0000_2000;
        step("tdiv_trap");
        excp_req = 0; excp_pc = 64'd0;
        step("tdiv_after");

        div_start = 1;
        step("rdiv_start");
        div_start = 0;
        repeat (4) step("rdiv_hold");
        rst_n = 0;
        step("rdiv_reset");
        rst_n = 1;
        div_done = 1;
        step("rdiv_done_ignored");
        div_done = 0;
        step("rdiv_after");

        for (int i = 0; i < 600; i++) begin
            stallreq_if  = ($urandom_range(3) == 0);
            stallreq_id  = ($urandom_range(3) == 0);
            stallreq_mem = ($urandom_range(5) == 0);
            div_start    = ($urandom_range(6) == 0);
            div_done     = ($urandom_range(9) == 0);
            mem_busy     = ($urandom_range(2) == 0);
            if (!m_trap) begin
                excp_req = ($urandom_range(14) == 0);
                excp_pc  = excp_req ? {$urandom, $urandom} : 64'd0;
            end
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
